tx_interp4: RTL

- Transmit-side ×4 interpolator for the I/Q baseband stream; the counterpart of the receive-side ×4 averaging decimator.
- Accepts one complex sample per 4 clocks at most through a valid/ready handshake.
- Emits one linearly interpolated complex sample per clock toward the DAC interface.
- Ramps from/to zero on stream start and underflow so the DAC sees no steps.

---
 rtl/tx_interp4.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/tx_interp4.sv
// tx_interp4: transmit-side x4 linear interpolator for the I/Q baseband stream.
// One complex sample is accepted at most every 4 clocks through a single-entry
// buffer; one interpolated sample is produced per clock toward the DAC. The
// stream ramps from zero at start and back to zero when the source runs dry,
// so the DAC never sees a step.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no stream; outputs held at 0, waiting for a buffered sample
//   RUN   | emitting one point per clock between prev and cur, ph = 0..3
//
// Within a block, output = ((4-ph)*prev + ph*cur) >>> 2. At ph==3 the block
// advances: the buffered sample becomes cur, or on underflow cur becomes 0
// (ramp-down block); a second empty block end returns to IDLE.

module tx_interp4 #(
   parameter int WIDTH = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in_I,
   input  logic [WIDTH-1:0] data_in_Q,
   output logic             out_valid,
   output logic [WIDTH-1:0] data_out_I,
   output logic [WIDTH-1:0] data_out_Q,
   output logic             underflow
);

   // Two guard bits hold 4*x and the weighted sum without overflow.
   localparam int IW = WIDTH + 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state, state_d;

   logic [1:0]       ph, ph_d;
   logic             nxt_full, nxt_full_d;
   logic [WIDTH-1:0] nxt_i, nxt_i_d, nxt_q, nxt_q_d;
   logic [WIDTH-1:0] prev_i, prev_i_d, prev_q, prev_q_d;
   logic [WIDTH-1:0] cur_i, cur_i_d, cur_q, cur_q_d;
   logic             zflag, zflag_d;
   logic             out_valid_d, underflow_d;
   logic [WIDTH-1:0] out_i_d, out_q_d;

   logic             accept;
   logic             block_end;
   logic [2:0]       w_cur, w_prev;
   logic signed [IW-1:0] wc_x, wp_x;
   logic signed [IW-1:0] prev_i_x, prev_q_x, cur_i_x, cur_q_x;
   logic signed [IW-1:0] sum_i, sum_q;
   logic [WIDTH-1:0] y_i, y_q;
   logic             unused_lsb;

   assign in_ready  = !nxt_full;
   assign accept    = in_valid && !nxt_full;
   assign block_end = (ph == 2'd3);

   // Weights for the current phase: prev gets 4-ph, cur gets ph.
   assign w_cur  = {1'b0, ph};
   assign w_prev = 3'd4 - w_cur;
   assign wc_x   = {{(IW-3){1'b0}}, w_cur};
   assign wp_x   = {{(IW-3){1'b0}}, w_prev};

   assign prev_i_x = {{2{prev_i[WIDTH-1]}}, prev_i};
   assign prev_q_x = {{2{prev_q[WIDTH-1]}}, prev_q};
   assign cur_i_x  = {{2{cur_i[WIDTH-1]}}, cur_i};
   assign cur_q_x  = {{2{cur_q[WIDTH-1]}}, cur_q};

   // Weighted sum of the two block endpoints, per rail.
   always_comb begin
      sum_i = wp_x * prev_i_x + wc_x * cur_i_x;
      sum_q = wp_x * prev_q_x + wc_x * cur_q_x;
   end

   // Dropping the two LSBs is the arithmetic shift by 2 (floor toward -inf).
   assign y_i        = sum_i[IW-1:2];
   assign y_q        = sum_q[IW-1:2];
   assign unused_lsb = ^{sum_i[1:0], sum_q[1:0]};

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   // Next-state: start on a buffered sample, stop after an empty ramp-down block.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (nxt_full) state_d = RUN;
         RUN:     if (block_end && !nxt_full && zflag) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values: buffer fill, block advance, interpolated point.
   always_comb begin
      ph_d        = ph;
      nxt_full_d  = nxt_full;
      nxt_i_d     = nxt_i;
      nxt_q_d     = nxt_q;
      prev_i_d    = prev_i;
      prev_q_d    = prev_q;
      cur_i_d     = cur_i;
      cur_q_d     = cur_q;
      zflag_d     = zflag;
      out_valid_d = 1'b0;
      out_i_d     = '0;
      out_q_d     = '0;
      underflow_d = 1'b0;

      // accept and consume are exclusive: consuming needs nxt_full, accepting needs !nxt_full
      if (accept) begin
         nxt_i_d    = data_in_I;
         nxt_q_d    = data_in_Q;
         nxt_full_d = 1'b1;
      end

      case (state)
         IDLE: begin
            if (nxt_full) begin
               cur_i_d    = nxt_i;
               cur_q_d    = nxt_q;
               prev_i_d   = '0;
               prev_q_d   = '0;
               ph_d       = 2'd0;
               nxt_full_d = 1'b0;
               zflag_d    = 1'b0;
            end
         end
         RUN: begin
            out_valid_d = 1'b1;
            out_i_d     = y_i;
            out_q_d     = y_q;
            ph_d        = ph + 2'd1;
            if (block_end) begin
               if (nxt_full) begin
                  prev_i_d   = cur_i;
                  prev_q_d   = cur_q;
                  cur_i_d    = nxt_i;
                  cur_q_d    = nxt_q;
                  nxt_full_d = 1'b0;
                  zflag_d    = 1'b0;
               end else if (!zflag) begin
                  prev_i_d    = cur_i;
                  prev_q_d    = cur_q;
                  cur_i_d     = '0;
                  cur_q_d     = '0;
                  zflag_d     = 1'b1;
                  underflow_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers; reset discards any queued sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph         <= 2'd0;
         nxt_full   <= 1'b0;
         nxt_i      <= '0;
         nxt_q      <= '0;
         prev_i     <= '0;
         prev_q     <= '0;
         cur_i      <= '0;
         cur_q      <= '0;
         zflag      <= 1'b0;
         out_valid  <= 1'b0;
         data_out_I <= '0;
         data_out_Q <= '0;
         underflow  <= 1'b0;
      end else begin
         ph         <= ph_d;
         nxt_full   <= nxt_full_d;
         nxt_i      <= nxt_i_d;
         nxt_q      <= nxt_q_d;
         prev_i     <= prev_i_d;
         prev_q     <= prev_q_d;
         cur_i      <= cur_i_d;
         cur_q      <= cur_q_d;
         zflag      <= zflag_d;
         out_valid  <= out_valid_d;
         data_out_I <= out_i_d;
         data_out_Q <= out_q_d;
         underflow  <= underflow_d;
      end
   end

endmodule
